// File: rtl/ro_sample_ctrl.sv
// rtl/ro_sample_ctrl.sv - ring-oscillator edge-count sampler with FWFT output buffer
module ro_sample_ctrl #(
  parameter int SIZE_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [SIZE_WIDTH-1:0]  num_samples,
  input  logic [SIZE_WIDTH-1:0]  collect_cycles,
  input  logic                   ro_tick,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_PUSH, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  logic [SIZE_WIDTH-1:0]  ns_q, cc_q, sample_cnt, win_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, hold_cnt, edge_next, push_data;
  logic [COUNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            fifo_cnt;
  logic                   fifo_full, pop, push, can_push, win_end, last_sample;

  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign out_valid   = (fifo_cnt != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign pop         = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts a write.
  assign can_push    = !fifo_full || pop;
  assign edge_next   = (ro_tick && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
  assign win_end     = (win_cnt == cc_q - 1'b1);
  assign last_sample = (sample_cnt == ns_q - 1'b1);

  always_comb begin
    push      = 1'b0;
    push_data = edge_next;
    if (state == S_COLLECT && win_end && can_push) begin
      push = 1'b1;
    end else if (state == S_PUSH && can_push) begin
      push      = 1'b1;
      push_data = hold_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ns_q       <= '0;
      cc_q       <= '0;
      sample_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            ns_q       <= num_samples;
            cc_q       <= (collect_cycles == '0) ? SIZE_WIDTH'(1) : collect_cycles;
            sample_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            if (num_samples == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_COLLECT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_COLLECT: begin
          if (win_end) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            if (can_push) begin
              sample_cnt <= sample_cnt + 1'b1;
              if (last_sample) state <= S_DRAIN;
            end else begin
              hold_cnt <= edge_next;
              state    <= S_PUSH;
            end
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= edge_next;
          end
        end
        S_PUSH: begin
          if (can_push) begin
            sample_cnt <= sample_cnt + 1'b1;
            state      <= last_sample ? S_DRAIN : S_COLLECT;
          end
        end
        S_DRAIN: begin
          // Finish on the accepting edge of the last entry so done rises the cycle after.
          if (fifo_cnt == '0 || (fifo_cnt == (AW+1)'(1) && pop)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// tb/tb_ro_sample_ctrl.sv - directed and randomized checks of ro_sample_ctrl
module tb_ro_sample_ctrl;

  localparam int MAXR = 600;

  logic        clk = 1'b0;
  logic        rst, go, ro_tick, out_ready, sel;
  logic [31:0] num_samples, collect_cycles;
  logic        ov0, busy0, done0, ov1, busy1, done1;
  logic [31:0] od0;
  logic [3:0]  od1;
  logic        ov, busy, done;
  logic [31:0] od;

  always #5 clk = ~clk;

  ro_sample_ctrl u_dut0 (
    .clk(clk), .rst(rst), .go(go & ~sel), .num_samples(num_samples),
    .collect_cycles(collect_cycles), .ro_tick(ro_tick), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .busy(busy0), .done(done0)
  );

  ro_sample_ctrl #(.SIZE_WIDTH(6), .COUNT_WIDTH(4), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .go(go & sel), .num_samples(num_samples[5:0]),
    .collect_cycles(collect_cycles[5:0]), .ro_tick(ro_tick), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .busy(busy1), .done(done1)
  );

  assign ov   = sel ? ov1 : ov0;
  assign od   = sel ? {28'b0, od1} : od0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;

  bit     tick_pat [MAXR];
  bit     ready_pat[MAXR];
  longint exp_q[$];
  longint got_q[$];
  int     nvec = 0;
  int     nerr = 0;
  int     rego_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected samples assuming no backpressure stall: window k spans cycles (k-1)*c+1 .. k*c after go.
  task automatic model_fill(input int ns, input int cc, input longint maxv);
    int c;
    longint s;
    c = (cc == 0) ? 1 : cc;
    exp_q.delete();
    for (int k = 0; k < ns; k++) begin
      s = 0;
      for (int j = 1; j <= c; j++) s += tick_pat[k*c + j];
      exp_q.push_back((s > maxv) ? maxv : s);
    end
  endtask

  task automatic set_pats(input int tick_mode, input int ready_from);
    for (int r = 0; r < MAXR; r++) begin
      case (tick_mode)
        0:       tick_pat[r] = 1'b0;
        1:       tick_pat[r] = 1'b1;
        2:       tick_pat[r] = (r % 2 == 1);
        default: tick_pat[r] = 1'($urandom_range(1, 0));
      endcase
      ready_pat[r] = (r >= ready_from);
    end
  endtask

  task automatic run_job(input bit s, input int ns, input int cc, input int max_r, input int abort_at);
    int last_acc, done_r;
    sel = s;
    got_q.delete();
    last_acc = 0;
    done_r = -1;
    for (int r = 0; r < max_r; r++) begin
      @(negedge clk);
      if (r == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", ov, 0);
        chk("abort_data", od, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b0;
        return;
      end
      go        = (r == 0) || (r == rego_at);
      ro_tick   = tick_pat[r];
      out_ready = ready_pat[r];
      if (r == 0) begin
        num_samples    = ns;
        collect_cycles = cc;
      end else if (r == rego_at) begin
        num_samples    = 7;
        collect_cycles = 2;
      end
      if (r > 0) begin
        if (r == 1) chk("busy_start", busy, (ns != 0));
        if (done && done_r < 0) done_r = r;
        if (ov && out_ready) begin
          got_q.push_back(longint'(od));
          last_acc = r;
        end else if (ov && got_q.size() < exp_q.size()) begin
          chk("hold_data", od, exp_q[got_q.size()]);
        end
        if (done_r >= 0 && r >= done_r + 2) break;
      end
    end
    go = 1'b0;
    chk("done_seen", (done_r >= 0), 1);
    if (done_r >= 0) chk("done_latency", done_r, last_acc + 1);
    chk("busy_end", busy, 0);
    chk("done_hold", done, 1);
    chk("valid_end", ov, 0);
    chk("sample_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("sample%0d", i), got_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; ro_tick = 1'b0; out_ready = 1'b0; sel = 1'b0;
    num_samples = '0; collect_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid0", ov0, 0);
    chk("rst_data0", od0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_valid1", ov1, 0);
    chk("rst_done1", done1, 0);
    rst = 1'b0;

    // three windows of 10 with a tick every other cycle; a go mid-run must be ignored
    set_pats(2, 0);
    model_fill(3, 10, 64'hFFFF_FFFF);
    rego_at = 5;
    run_job(0, 3, 10, 100, -1);
    rego_at = -1;
    for (int i = 0; i < exp_q.size(); i++) chk("req031_five", exp_q[i], 5);

    // zero window length behaves as one
    set_pats(1, 0);
    exp_q = '{1, 1};
    run_job(0, 2, 0, 40, -1);

    // zero samples
    set_pats(1, 0);
    exp_q.delete();
    run_job(0, 0, 5, 20, -1);

    // backpressure: four stored, fifth held, sixth window after release
    set_pats(0, 100);
    for (int k = 1; k <= 5; k++)
      for (int j = 1; j <= k; j++) tick_pat[(k-1)*8 + j] = 1'b1;
    for (int r = 100; r < MAXR; r++) tick_pat[r] = 1'b1;
    exp_q = '{1, 2, 3, 4, 5, 8};
    run_job(0, 6, 8, 200, -1);

    // 4-bit counts saturate
    set_pats(1, 0);
    exp_q = '{15, 15};
    run_job(1, 2, 40, 120, -1);

    // maximum sample count for a 6-bit size field
    set_pats(3, 0);
    model_fill(63, 0, 15);
    run_job(1, 63, 0, 120, -1);

    for (int t = 0; t < 6; t++) begin
      int ns, cc;
      ns = $urandom_range(5, 1);
      cc = $urandom_range(8, 0);
      set_pats(3, 0);
      model_fill(ns, cc, 64'hFFFF_FFFF);
      run_job(0, ns, cc, 100, -1);
    end

    // abort with two samples buffered, then a clean single-sample job
    set_pats(1, MAXR);
    exp_q = '{3, 3, 3, 3, 3};
    run_job(0, 5, 3, 20, 8);
    set_pats(3, 0);
    model_fill(1, 4, 64'hFFFF_FFFF);
    run_job(0, 1, 4, 30, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ro_sample_ctrl.md
RO_SAMPLE_CTRL -- requirements
Module: ro_sample_ctrl

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 32, width of num_samples and collect_cycles.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of each RO edge-count sample.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 go  input  1  single-cycle start pulse from the MMIO register block.
REQ-007 num_samples  input  SIZE_WIDTH  number of samples to produce; captured on go.
REQ-008 collect_cycles  input  SIZE_WIDTH  clk cycles per sampling window; captured on go.
REQ-009 ro_tick  input  1  one-cycle pulse per RO rising edge, already synchronized to clk.
REQ-010 out_valid  output  1  sample available to the DMA write stage.
REQ-011 out_ready  input  1  DMA write stage accepts sample when out_valid && out_ready.
REQ-012 out_data  output  COUNT_WIDTH  edge count of one window.
REQ-013 busy  output  1  high in any state other than IDLE and DONE.
REQ-014 done  output  1  level, high when all samples accepted downstream; read back by MMIO.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, PUSH, DRAIN, DONE.
REQ-016 IDLE/DONE + go: SHALL capture num_samples and collect_cycles, clear sample/window/edge counters, clear done, go to COLLECT next cycle; num_samples==0 -> DONE next cycle.
REQ-017 collect_cycles==0 SHALL be treated as 1.
REQ-018 go while busy SHALL be ignored; captured values SHALL be unchanged.
REQ-019 COLLECT: window counter increments each cycle; edge counter increments on each ro_tick and saturates at all-ones.
REQ-020 COLLECT window length SHALL be exactly the captured collect_cycles; an ro_tick in the last window cycle SHALL count toward that window.
REQ-021 At window end, if FIFO not full, count SHALL be written to FIFO that cycle; edge counter restarts at 0 (or 1 if ro_tick that cycle does not belong to old window -- it does, so 0); next window starts next cycle.
REQ-022 At window end with FIFO full: go to PUSH holding the count; edge counting suspended; write when space appears, then resume COLLECT (or DRAIN) next cycle.
REQ-023 After sample num_samples is written to FIFO: go to DRAIN; ro_tick ignored.
REQ-024 DRAIN -> DONE when FIFO empty and no transfer pending; done SHALL assert in the cycle after the last out_valid&&out_ready.
REQ-025 DONE: done held high until next go.
REQ-026 FIFO: first-word-fall-through; out_valid = not empty; out_data = head entry; simultaneous push and pop when full or empty SHALL be legal and lossless.
REQ-027 out_data SHALL remain stable while out_valid && !out_ready.
REQ-028 Sample counter SHALL be SIZE_WIDTH bits; num_samples = 2^SIZE_WIDTH-1 SHALL complete without wrap error.

Reset
REQ-029 On rst: state IDLE, FIFO empty, all counters 0, out_valid 0, out_data 0, busy 0, done 0.
REQ-030 rst mid-operation SHALL abort immediately; buffered samples discarded; next go starts cleanly.

Verification
REQ-031 go, num_samples=3, collect_cycles=10, ro_tick every 2nd cycle, out_ready=1 -> three samples of 5, done 1 cycle after third accept, busy low.
REQ-032 collect_cycles=0, ro_tick constant 1, num_samples=2 -> two samples of 1.
REQ-033 num_samples=0 -> done high 1 cycle after go, out_valid never asserted.
REQ-034 FIFO_DEPTH=4, num_samples=6, out_ready=0 until 100 cycles -> FSM stalls in PUSH after 4 stored, no sample lost, order preserved, all 6 delivered after out_ready=1.
REQ-035 COUNT_WIDTH=4, ro_tick constant 1, collect_cycles=40 -> sample value 15 (saturated).
REQ-036 rst asserted mid COLLECT with 2 samples buffered -> out_valid 0 immediately; fresh go num_samples=1 yields exactly one correct sample.
